// File: rtl/writeback_stage_v2_pkg.sv
// rtl/writeback_stage_v2_pkg.sv - shared constants for the writeback stage
package writeback_stage_v2_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Stores, branches and fences retire without producing a register result.
    function automatic logic op_writes_rf(input logic [6:0] opcode);
        return !(opcode == OP_STORE || opcode == OP_BRANCH || opcode == OP_FENCE);
    endfunction

endpackage

// File: rtl/writeback_stage_v2_load_formatter.sv
// rtl/writeback_stage_v2_load_formatter.sv - load data alignment and extension
module writeback_stage_v2_load_formatter
    import writeback_stage_v2_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  data_i,
    input  logic [2:0]       funct3_i,
    input  logic [OFF_W-1:0] off_i,
    output logic [XLEN-1:0]  data_o,
    output logic             illegal_o
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] shifted_h;

    // Shift the addressed bytes down to bit 0, then extend per access size.
    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        shifted   = data_i >> {off_i, 3'b000};
        shifted_h = data_i >> {off_i[OFF_W-1:1], 4'b0000};
        case (funct3_i)
            F3_LB:   data_o = XLEN'($signed(shifted[7:0]));
            F3_LBU:  data_o = XLEN'(shifted[7:0]);
            F3_LH:   data_o = XLEN'($signed(shifted_h[15:0]));
            F3_LHU:  data_o = XLEN'(shifted_h[15:0]);
            F3_LW:   data_o = XLEN'($signed(shifted[31:0]));
            F3_LWU: begin
                if (XLEN == 64) data_o = XLEN'(shifted[31:0]);
                else            illegal_o = 1'b1;
            end
            F3_LD: begin
                if (XLEN == 64) data_o = shifted;
                else            illegal_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage_v2.sv
// rtl/writeback_stage_v2.sv - writeback stage with holding buffer and RF port arbitration
module writeback_stage_v2
    import writeback_stage_v2_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int RA_W      = 5,
    parameter int OFF_W     = $clog2(XLEN / 8),
    parameter int CNT_W     = 64,
    parameter int MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [RA_W-1:0]  i_rd,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic [OFF_W-1:0] i_addr_lsb,
    input  logic [XLEN-1:0]  i_wb_data,
    input  logic             i_ext_wr_req,
    input  logic [RA_W-1:0]  i_ext_rd,
    input  logic [XLEN-1:0]  i_ext_data,
    output logic             o_ext_ack,
    output logic             o_rf_wr,
    output logic [RA_W-1:0]  o_rf_rd,
    output logic [XLEN-1:0]  o_rf_data,
    output logic             o_fwd_vld,
    output logic [RA_W-1:0]  o_fwd_rd,
    output logic [XLEN-1:0]  o_fwd_data,
    output logic [CNT_W-1:0] o_instret
);

    localparam int SC_W = 4;

    logic             full_q;
    logic             wr_q;
    logic [RA_W-1:0]  rd_q;
    logic [XLEN-1:0]  data_q;
    logic [SC_W-1:0]  stall_q;
    logic [CNT_W-1:0] instret_q;

    logic [XLEN-1:0]  fmt_data;
    logic             fmt_illegal;
    logic             is_load;
    logic [XLEN-1:0]  new_data;
    logic             new_wr;
    logic             ext_wins;
    logic             commit;
    logic             accept;

    writeback_stage_v2_load_formatter #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_load_formatter (
        .data_i    (i_wb_data),
        .funct3_i  (i_funct3),
        .off_i     (i_addr_lsb),
        .data_o    (fmt_data),
        .illegal_o (fmt_illegal)
    );

    // Format the incoming entry and decide whether it will write the RF.
    always_comb begin
        is_load  = (i_opcode == OP_LOAD);
        new_data = is_load ? fmt_data : i_wb_data;
        new_wr   = op_writes_rf(i_opcode) && (i_rd != '0) && !(is_load && fmt_illegal);
    end

    // Port arbitration: the external writer wins until the buffered entry has lost MAX_STALL times.
    always_comb begin
        ext_wins = rst_n && i_ext_wr_req && (!full_q || (stall_q < SC_W'(MAX_STALL)));
        commit   = full_q && !ext_wins;
        o_rdy    = rst_n && (!full_q || commit);
        accept   = i_vld && o_rdy;
    end

    // Drive the RF port from the buffer on commit, otherwise from the granted external writer.
    always_comb begin
        o_ext_ack  = ext_wins;
        o_rf_wr    = 1'b0;
        o_rf_rd    = '0;
        o_rf_data  = '0;
        o_fwd_vld  = full_q && wr_q;
        o_fwd_rd   = o_fwd_vld ? rd_q : '0;
        o_fwd_data = o_fwd_vld ? data_q : '0;
        o_instret  = instret_q;
        if (commit) begin
            o_rf_wr   = wr_q;
            o_rf_rd   = rd_q;
            o_rf_data = data_q;
        end else if (ext_wins) begin
            o_rf_wr   = (i_ext_rd != '0);
            o_rf_rd   = i_ext_rd;
            o_rf_data = i_ext_data;
        end
    end

    // Buffer, starvation counter and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 1'b0;
            wr_q      <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
            stall_q   <= '0;
            instret_q <= '0;
        end else begin
            if (accept) begin
                full_q <= 1'b1;
                wr_q   <= new_wr;
                rd_q   <= i_rd;
                data_q <= new_data;
            end else if (commit) begin
                full_q <= 1'b0;
            end
            if (commit) begin
                stall_q   <= '0;
                instret_q <= instret_q + CNT_W'(1);
            end else if (full_q && ext_wins) begin
                stall_q <= stall_q + SC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage_v2.sv
// tb/tb_writeback_stage_v2.sv - self-checking bench for writeback_stage_v2
module tb_writeback_stage_v2;

    localparam int XLEN      = 32;
    localparam int RA_W      = 5;
    localparam int OFF_W     = 2;
    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 2;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] ALU    = 7'b0110011;
    localparam logic [6:0] ADDI   = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_vld = 1'b0;
    logic             o_rdy;
    logic [RA_W-1:0]  i_rd = '0;
    logic [6:0]       i_opcode = '0;
    logic [2:0]       i_funct3 = '0;
    logic [OFF_W-1:0] i_addr_lsb = '0;
    logic [XLEN-1:0]  i_wb_data = '0;
    logic             i_ext_wr_req = 1'b0;
    logic [RA_W-1:0]  i_ext_rd = '0;
    logic [XLEN-1:0]  i_ext_data = '0;
    logic             o_ext_ack;
    logic             o_rf_wr;
    logic [RA_W-1:0]  o_rf_rd;
    logic [XLEN-1:0]  o_rf_data;
    logic             o_fwd_vld;
    logic [RA_W-1:0]  o_fwd_rd;
    logic [XLEN-1:0]  o_fwd_data;
    logic [CNT_W-1:0] o_instret;

    writeback_stage_v2 #(
        .XLEN (XLEN), .RA_W (RA_W), .OFF_W (OFF_W), .CNT_W (CNT_W), .MAX_STALL (MAX_STALL)
    ) dut (
        .clk (clk), .rst_n (rst_n), .i_vld (i_vld), .o_rdy (o_rdy), .i_rd (i_rd),
        .i_opcode (i_opcode), .i_funct3 (i_funct3), .i_addr_lsb (i_addr_lsb),
        .i_wb_data (i_wb_data), .i_ext_wr_req (i_ext_wr_req), .i_ext_rd (i_ext_rd),
        .i_ext_data (i_ext_data), .o_ext_ack (o_ext_ack), .o_rf_wr (o_rf_wr),
        .o_rf_rd (o_rf_rd), .o_rf_data (o_rf_data), .o_fwd_vld (o_fwd_vld),
        .o_fwd_rd (o_fwd_rd), .o_fwd_data (o_fwd_data), .o_instret (o_instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state: the one pending entry, how often it has lost the port, retired count
    bit          m_full;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    bit          m_wr;
    int          m_stall;
    int          m_cnt;

    // values sampled in the last cycle, for directed scenario checks
    logic        s_rdy, s_ack, s_rf_wr;
    logic [4:0]  s_rf_rd;
    logic [31:0] s_rf_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void fmt_ref(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] off,
                                    input logic [31:0] w, input logic [4:0] rd,
                                    output logic [31:0] val, output bit wr);
        bit ill = 0;
        int b;
        val = w;
        if (op == LOAD) begin
            case (f3)
                3'd0: begin b = int'((w >> (8 * off)) & 32'hFF);   val = (b >= 128)   ? 32'(b - 256)   : 32'(b); end
                3'd4: begin b = int'((w >> (8 * off)) & 32'hFF);   val = 32'(b); end
                3'd1: begin b = int'((w >> (8 * (off & 2))) & 32'hFFFF); val = (b >= 32768) ? 32'(b - 65536) : 32'(b); end
                3'd5: begin b = int'((w >> (8 * (off & 2))) & 32'hFFFF); val = 32'(b); end
                3'd2: val = w >> (8 * off);
                default: begin val = 0; ill = 1; end
            endcase
        end
        wr = !(op == STORE || op == BRANCH || op == FENCE) && (rd != 0) && !ill;
    endfunction

    task automatic drv(input bit vld, input logic [4:0] rd, input logic [6:0] op,
                       input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        i_vld = vld; i_rd = rd; i_opcode = op; i_funct3 = f3; i_addr_lsb = off; i_wb_data = d;
    endtask

    task automatic cycle();
        bit ew, cm, rdy, ewr;
        logic [31:0] v;
        bit w;
        @(negedge clk);
        ew  = i_ext_wr_req && (!m_full || m_stall < MAX_STALL);
        cm  = m_full && !ew;
        rdy = !m_full || cm;
        ewr = cm ? m_wr : (ew ? (i_ext_rd != 0) : 1'b0);
        s_rdy = o_rdy; s_ack = o_ext_ack; s_rf_wr = o_rf_wr; s_rf_rd = o_rf_rd; s_rf_data = o_rf_data;
        check("rdy", o_rdy, rdy);
        check("ext_ack", o_ext_ack, ew);
        check("rf_wr", o_rf_wr, ewr);
        if (ewr) begin
            check("rf_rd", o_rf_rd, cm ? m_rd : i_ext_rd);
            check("rf_data", o_rf_data, cm ? m_data : i_ext_data);
        end
        check("fwd_vld", o_fwd_vld, m_full && m_wr);
        check("fwd_rd", o_fwd_rd, (m_full && m_wr) ? m_rd : 5'd0);
        check("fwd_data", o_fwd_data, (m_full && m_wr) ? m_data : 32'd0);
        check("instret", o_instret, m_cnt);
        fmt_ref(i_opcode, i_funct3, i_addr_lsb, i_wb_data, i_rd, v, w);
        @(posedge clk);
        if (cm) begin
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
            m_stall = 0;
        end else if (m_full && ew) begin
            m_stall++;
        end
        if (i_vld && rdy) begin
            m_full = 1; m_rd = i_rd; m_data = v; m_wr = w;
        end else if (cm) begin
            m_full = 0;
        end
        #1;
    endtask

    // Asserts reset away from a clock edge, checks the quiet outputs, then releases it.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_rdy", o_rdy, 0);
        check("rst_ack", o_ext_ack, 0);
        check("rst_rf_wr", o_rf_wr, 0);
        check("rst_rf_rd", o_rf_rd, 0);
        check("rst_rf_data", o_rf_data, 0);
        check("rst_fwd_vld", o_fwd_vld, 0);
        check("rst_fwd_data", o_fwd_data, 0);
        check("rst_instret", o_instret, 0);
        m_full = 0; m_stall = 0; m_cnt = 0; m_wr = 0; m_rd = 0; m_data = 0;
        drv(0, 0, ALU, 0, 0, 0);
        i_ext_wr_req = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", o_rdy, 1);
        check("post_rst_instret", o_instret, 0);
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [7];

    initial begin
        ops = '{LOAD, LOAD, ALU, ADDI, STORE, BRANCH, FENCE};
        @(posedge clk);
        #1;
        do_reset();

        // back-to-back ALU results
        drv(1, 5, ALU, 0, 0, 32'h11); cycle();
        check("b2b_rdy0", s_rdy, 1);
        drv(1, 6, ALU, 0, 0, 32'h22); cycle();
        check("b2b_w0_wr", s_rf_wr, 1); check("b2b_w0_rd", s_rf_rd, 5); check("b2b_w0_d", s_rf_data, 32'h11);
        check("b2b_rdy1", s_rdy, 1);
        drv(0, 0, ALU, 0, 0, 0); cycle();
        check("b2b_w1_rd", s_rf_rd, 6); check("b2b_w1_d", s_rf_data, 32'h22);
        check("b2b_instret", o_instret, 2);

        // load formatting
        drv(1, 10, LOAD, 3'b000, 0, 32'h8000_F0A5); cycle(); check("lb_off0", o_fwd_data, 32'hFFFF_FFA5);
        drv(1, 11, LOAD, 3'b100, 1, 32'h8000_F0A5); cycle(); check("lbu_off1", o_fwd_data, 32'h0000_00F0);
        drv(1, 12, LOAD, 3'b001, 2, 32'h8000_F0A5); cycle(); check("lh_off2", o_fwd_data, 32'hFFFF_8000);
        drv(1, 13, LOAD, 3'b101, 3, 32'h8000_F0A5); cycle(); check("lhu_off3", o_fwd_data, 32'h0000_8000);
        drv(1, 14, LOAD, 3'b111, 0, 32'h8000_F0A5); cycle(); check("illegal_nofwd", o_fwd_vld, 0);
        drv(0, 0, ALU, 0, 0, 0); cycle();

        // arbitration against a persistent external writer
        drv(1, 3, ALU, 0, 0, 32'hAA); cycle();
        drv(0, 0, ALU, 0, 0, 0);
        i_ext_wr_req = 1; i_ext_rd = 9; i_ext_data = 32'h55;
        cycle(); check("arb_c1_ack", s_ack, 1); check("arb_c1_rdy", s_rdy, 0);
        cycle(); check("arb_c2_ack", s_ack, 1); check("arb_c2_rdy", s_rdy, 0);
        cycle(); check("arb_c3_ack", s_ack, 0); check("arb_c3_rd", s_rf_rd, 3); check("arb_c3_d", s_rf_data, 32'hAA);
        cycle(); check("arb_c4_ack", s_ack, 1); check("arb_c4_rd", s_rf_rd, 9);
        i_ext_wr_req = 0;
        cycle();

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            drv($urandom_range(0, 3) != 0, ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                ops[$urandom_range(0, 6)], 3'($urandom), 2'($urandom), $urandom);
            if ($urandom_range(0, 5) == 0) i_opcode = LUI;
            i_ext_wr_req = ($urandom_range(0, 9) < 4);
            i_ext_rd     = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            i_ext_data   = $urandom;
            cycle();
        end
        i_ext_wr_req = 0;

        // reset with a full buffer discards the entry
        drv(1, 20, ALU, 0, 0, 32'hDEAD); cycle();
        check("midrst_full", o_fwd_vld, 1);
        i_ext_wr_req = 1; i_ext_rd = 4;
        do_reset();
        cycle();
        check("midrst_nowrite", s_rf_wr, 0);

        // suppression of stores and x0 writes
        do_reset();
        drv(1, 7, STORE, 3'b010, 0, 32'h77); cycle(); check("store_nofwd", o_fwd_vld, 0);
        drv(1, 0, ADDI, 0, 0, 32'h5); cycle(); check("x0_nofwd", o_fwd_vld, 0); check("store_nowr", s_rf_wr, 0);
        drv(0, 0, ALU, 0, 0, 0); cycle(); check("x0_nowr", s_rf_wr, 0);
        check("supp_instret", o_instret, 2);

        // instret wraps at 2^CNT_W
        do_reset();
        for (int n = 0; n < 17; n++) begin
            drv(1, 5'(n + 1), ALU, 0, 0, 32'(n));
            cycle();
        end
        drv(0, 0, ALU, 0, 0, 0); cycle();
        check("instret_wrap", o_instret, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
